// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned DefCntW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStopPend
    } state_e;

    // Config word at the default counter width.
    typedef struct packed {
        logic [DefCntW-1:0] period;
        logic [DefCntW-1:0] high;
    } cfg_t;

    // A usable config needs at least one high and one low cycle per period.
    function automatic logic cfg_is_valid(input int unsigned period, input int unsigned high);
        return (period >= 2) && (high != 0) && (high < period);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and high/low comparator; clk_out is registered from next-cycle values.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run,     // block is running in the next cycle
    input  logic             load,    // restart the count at zero (leaving idle)
    input  logic [CNT_W-1:0] period,  // period in effect this cycle
    input  logic [CNT_W-1:0] high,    // high time in effect next cycle
    output logic             clk_out,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;

    // Last cycle of the period; cnt stays 0 when idle and period >= 2, so idle never wraps.
    assign wrap    = (cnt_q == period - CNT_W'(1));
    assign clk_out = clk_q;

    // Next count and next output level.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!run || load || wrap) begin
            cnt_d = '0;
        end
        clk_d = run && (cnt_d < high);
    end

    // Counter and output register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller: start/stop FSM, pending config slot and config validation.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned DEF_PERIOD = 10,
    parameter int unsigned DEF_HIGH   = 6
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             period_tick,
    output logic             running,
    output logic [CNT_W-1:0] cur_period,
    output logic [CNT_W-1:0] cur_high
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
    } slot_t;

    if (CNT_W < 2 || CNT_W > 31) begin : g_bad_width
        $error("clk_div_ctrl: CNT_W must be in 2..31");
    end
    if (DEF_PERIOD >= (32'd1 << CNT_W) || !cfg_is_valid(DEF_PERIOD, DEF_HIGH)) begin : g_bad_def
        $error("clk_div_ctrl: DEF_PERIOD/DEF_HIGH invalid");
    end

    state_e state_q, state_d;
    slot_t  cur_q, cur_d;
    slot_t  slot_q, slot_d;
    slot_t  cfg_in;
    logic   slot_full_q, slot_full_d;
    logic   err_q, err_d;
    logic   wrap;
    logic   cfg_fire;
    logic   cfg_ok;

    assign cfg_in     = '{period: cfg_period, high: cfg_high};
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign cfg_ok     = cfg_is_valid(32'(cfg_period), 32'(cfg_high));
    assign cfg_err    = err_q;
    assign cur_period = cur_q.period;
    assign cur_high   = cur_q.high;

    // State register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a stop only takes effect on a wrap, and re-enabling cancels it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StRun;
            end
            StRun: begin
                if (!enable) state_d = wrap ? StIdle : StStopPend;
            end
            StStopPend: begin
                if (enable)    state_d = StRun;
                else if (wrap) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        running     = (state_q != StIdle);
        cfg_ready   = !slot_full_q;
        period_tick = wrap;
    end

    // Config routing: straight to cur_* when idle, via the pending slot when running.
    always_comb begin
        cur_d       = cur_q;
        slot_d      = slot_q;
        slot_full_d = slot_full_q;
        err_d       = cfg_fire && !cfg_ok;
        if (state_q == StIdle) begin
            // A config accepted on the stopping wrap is still in the slot; flush it now.
            if (slot_full_q) begin
                cur_d       = slot_q;
                slot_full_d = 1'b0;
            end
            if (cfg_fire && cfg_ok) cur_d = cfg_in;
        end else begin
            if (wrap && slot_full_q) begin
                cur_d       = slot_q;
                slot_full_d = 1'b0;
            end
            // cfg_fire implies the slot was empty, so this never collides with the apply above.
            if (cfg_fire && cfg_ok) begin
                slot_d      = cfg_in;
                slot_full_d = 1'b1;
            end
        end
    end

    // Config registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cur_q       <= '{period: CNT_W'(DEF_PERIOD), high: CNT_W'(DEF_HIGH)};
            slot_q      <= '0;
            slot_full_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            slot_q      <= slot_d;
            slot_full_q <= slot_full_d;
            err_q       <= err_d;
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_in  (clk_in),
        .reset   (reset),
        .run     (state_d != StIdle),
        .load    (state_q == StIdle),
        .period  (cur_q.period),
        .high    (cur_d.high),
        .clk_out (clk_out),
        .wrap    (wrap)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a cycle model pushes expected outputs, a monitor compares.
module tb_clk_div_ctrl;
    import clk_div_pkg::*;

    localparam int unsigned W = DefCntW;

    logic         clk_in = 1'b0;
    logic         reset;
    logic         enable;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_high;
    logic         cfg_err;
    logic         clk_out;
    logic         period_tick;
    logic         running;
    logic [W-1:0] cur_period;
    logic [W-1:0] cur_high;

    always #5 clk_in = ~clk_in;

    clk_div_ctrl #(
        .CNT_W      (W),
        .DEF_PERIOD (10),
        .DEF_HIGH   (6)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_err     (cfg_err),
        .clk_out     (clk_out),
        .period_tick (period_tick),
        .running     (running),
        .cur_period  (cur_period),
        .cur_high    (cur_high)
    );

    typedef struct {
        bit clk;
        bit tick;
        bit run;
        int per;
        int hi;
        bit ready;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the period, settings in effect, one pending config.
    bit m_run  = 0;
    int m_cnt  = 0;
    int m_per  = 10;
    int m_hi   = 6;
    bit m_pend = 0;
    cfg_t m_slot;
    bit m_err  = 0;

    initial begin
        exp_t e;
        bit   fire, ok, at_end;
        int   p, h;
        forever begin
            @(posedge clk_in);
            if (!reset) begin
                m_run = 0; m_cnt = 0; m_per = 10; m_hi = 6; m_pend = 0; m_err = 0;
            end else begin
                p      = int'(cfg_period);
                h      = int'(cfg_high);
                fire   = cfg_valid && !m_pend;
                ok     = (p >= 2) && (h != 0) && (h < p);
                at_end = m_run && (m_cnt == m_per - 1);
                m_err  = fire && !ok;
                if (!m_run) begin
                    if (m_pend) begin
                        m_per = int'(m_slot.period); m_hi = int'(m_slot.high); m_pend = 0;
                    end
                    if (fire && ok) begin m_per = p; m_hi = h; end
                    if (enable) begin m_run = 1; m_cnt = 0; end
                end else begin
                    if (at_end) begin
                        m_cnt = 0;
                        if (m_pend) begin
                            m_per = int'(m_slot.period); m_hi = int'(m_slot.high); m_pend = 0;
                        end
                        if (!enable) m_run = 0;
                    end else begin
                        m_cnt++;
                    end
                    if (fire && ok) begin
                        m_slot = '{period: W'(p), high: W'(h)};
                        m_pend = 1;
                    end
                end
            end
            e.clk   = m_run && (m_cnt < m_hi);
            e.tick  = m_run && (m_cnt == m_per - 1);
            e.run   = m_run;
            e.per   = m_per;
            e.hi    = m_hi;
            e.ready = !m_pend;
            e.err   = m_err;
            exp_q.push_back(e);
        end
    end

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("clk_out", int'(clk_out), int'(e.clk));
                check("period_tick", int'(period_tick), int'(e.tick));
                check("running", int'(running), int'(e.run));
                check("cur_period", int'(cur_period), e.per);
                check("cur_high", int'(cur_high), e.hi);
                check("cfg_ready", int'(cfg_ready), int'(e.ready));
                check("cfg_err", int'(cfg_err), int'(e.err));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Holds cfg_valid until a handshake completes, bounded.
    task automatic send_cfg(input int p, input int h);
        bit took = 0;
        cfg_valid  = 1'b1;
        cfg_period = W'(p);
        cfg_high   = W'(h);
        for (int i = 0; i < 100 && !took; i++) begin
            @(negedge clk_in);
            took = cfg_ready;
            @(posedge clk_in);
            #1;
        end
        cfg_valid = 1'b0;
        check("cfg_accept", int'(took), 1);
    endtask

    // Waits (bounded) for the negedge of a cycle where the model count equals k.
    task automatic sync_cnt(input int k);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_in);
            got = m_run && (m_cnt == k);
        end
        check("sync_cnt", int'(got), 1);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;
        step(3);
        reset = 1'b1;
        step(1);

        // Default waveform.
        enable = 1'b1;
        step(25);

        // Clean stop from cnt=2.
        sync_cnt(1);
        @(posedge clk_in); #1;
        enable = 1'b0;
        step(15);

        // Restart, then cancel a stop during STOP_PEND.
        enable = 1'b1;
        step(13);
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        step(12);

        // Live reconfig, then an invalid config.
        step(3);
        send_cfg(4, 1);
        step(20);
        send_cfg(5, 5);
        step(12);

        // Config while idle takes effect immediately.
        enable = 1'b0;
        step(10);
        send_cfg(3, 2);
        check("idle_cfg_period", int'(cur_period), 3);
        check("idle_cfg_high", int'(cur_high), 2);
        step(2);
        enable = 1'b1;
        step(10);

        // Accept on a wrap cycle so the config stays pending, then reset while clk_out is high.
        sync_cnt(1);
        @(posedge clk_in); #1;
        cfg_valid = 1'b1; cfg_period = W'(7); cfg_high = W'(3);
        @(posedge clk_in); #1;
        cfg_valid = 1'b0;
        @(negedge clk_in);
        check("clk_out_before_reset", int'(clk_out), 1);
        check("pending_before_reset", int'(cfg_ready), 0);
        #2 reset = 1'b0;
        #1;
        check("clk_out_async_reset", int'(clk_out), 0);
        check("running_async_reset", int'(running), 0);
        check("ready_async_reset", int'(cfg_ready), 1);
        @(posedge clk_in); #1;
        reset = 1'b1;
        check("reset_cur_period", int'(cur_period), 10);
        check("reset_cur_high", int'(cur_high), 6);
        step(25);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            cfg_valid  = ($urandom_range(0, 5) == 0);
            cfg_period = W'($urandom_range(0, 12));
            cfg_high   = W'($urandom_range(0, 12));
            step(1);
        end
        cfg_valid = 1'b0;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the programmable clock divider. It generates a divided clock of PERIOD input cycles with HIGH cycles high, and starts and stops it cleanly on request. It accepts new period/high settings through a valid/ready handshake and applies them only on a period boundary, so the output never glitches. It sits between the register/config logic and the clock-divided consumers.

Parameters:
CNT_W, 8, width of the period/high counters and config fields
DEF_PERIOD, 10, period loaded at reset; must be >=2
DEF_HIGH, 6, high time loaded at reset; must satisfy 1 <= DEF_HIGH <= DEF_PERIOD-1. An invalid default is an elaboration error.

Ports:
clk_in  input  1  single system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  level request to run the divided clock
cfg_valid  input  1  config request valid
cfg_ready  output  1  config slot free; transfer occurs when cfg_valid && cfg_ready
cfg_period  input  CNT_W  requested period in clk_in cycles
cfg_high  input  CNT_W  requested high time in clk_in cycles
cfg_err  output  1  one-cycle pulse: accepted config was invalid and was dropped
clk_out  output  1  divided clock, registered
period_tick  output  1  one-cycle pulse on the last cycle of each output period
running  output  1  high in RUN and STOP_PEND
cur_period  output  CNT_W  period currently in effect
cur_high  output  CNT_W  high time currently in effect

Behaviour:
- Reset values (reset low, asynchronous):
  - state=IDLE, cnt=0, clk_out=0, period_tick=0, running=0, cfg_err=0, cfg_ready=1.
  - cur_period=DEF_PERIOD, cur_high=DEF_HIGH, pending slot empty.
  - Reset asserted mid-operation forces clk_out low immediately and discards any pending config.
- States: IDLE, RUN, STOP_PEND.
- IDLE:
  - clk_out=0 and cnt=0.
  - An accepted valid config is written directly to cur_* on the next edge.
  - enable=1 moves to RUN on the next edge with cnt=0.
- RUN:
  - cnt counts 0..cur_period-1 and wraps to 0.
  - In the cycle where cnt=k, clk_out=1 iff k < cur_high. Latency: first high cycle of clk_out is the first cycle after entering RUN.
  - period_tick=1 in the cycle with cnt=cur_period-1.
- Config while running (RUN or STOP_PEND):
  - Single pending slot; cfg_ready=0 while the slot is full.
  - An accepted config goes to the slot and is copied to cur_* at the first wrap strictly after the acceptance cycle. Acceptance in the same cycle as a wrap therefore waits one full period.
  - The new period begins with cnt=0 using the new values.
  - The slot empties on apply, and cfg_ready returns to 1 in the next cycle.
- Validation, applied at acceptance in every state:
  - A config is invalid if cfg_period < 2, cfg_high == 0, or cfg_high >= cfg_period.
  - An invalid config is consumed (handshake completes) but not stored.
  - cfg_err pulses in the cycle after acceptance.
- Stopping:
  - enable=0 in RUN moves to STOP_PEND. The current period completes, and at the wrap the block goes to IDLE (clk_out=0, cnt=0).
  - A pending config is applied at that same wrap.
  - enable=1 again during STOP_PEND returns to RUN with no interruption of counting.
- Width rules: all compares are unsigned on CNT_W bits. No arithmetic overflow is possible because cnt < cur_period <= 2^CNT_W-1.

Decomposition:
- Package clk_div_pkg holds:
  - state enum {IDLE, RUN, STOP_PEND};
  - a packed cfg struct {period, high};
  - the cfg_is_valid function;
  - CNT_W default.
- One natural sub-module, clk_div_core: the counter plus high/low comparator. Inputs: run, period, high, load strobe. Outputs: clk_out, wrap.
- clk_div_ctrl keeps the FSM, the pending slot and validation.

Test Plan:
- Defaults: release reset, enable=1 -> clk_out repeats 6 high / 4 low; period_tick every 10 cycles; cur_period=10, cur_high=6.
- Live reconfig: in RUN mid-period send period=4, high=1 -> cfg_ready drops; current 10-cycle period completes; then 1 high / 3 low; cfg_ready returns to 1.
- Invalid config: send period=5, high=5 -> cfg_err pulses once; cur_* unchanged; waveform unchanged.
- Clean stop/restart: drop enable at cnt=2 -> clk_out finishes the period (through cnt=9) and then stays 0. Re-raise enable during STOP_PEND in a second run -> no gap in the waveform.
- Config in IDLE: period=3, high=2 while idle -> cur_* update on the next edge; enable -> 2 high / 1 low from the first period.
- Mid-operation reset: assert reset while clk_out=1 with a config pending -> clk_out=0 immediately; after release cur_*=10/6 and the pending config is lost.
